// File: rtl/msg_ser_tx.sv
// Serial frame transmitter: start bit, 2-bit port, 4-bit byte count, payload bytes MSB first, idle gap.
// Payload bytes are fetched through a one-byte holding buffer; a missing byte is sent as zeros.
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | line high, waiting for a frame request
// S_START | start bit (0) on the line
// S_PORT  | two port bits, MSB first
// S_COUNT | four byte-count bits, MSB first
// S_DATA  | payload bits, 8 per byte, MSB first
// S_GAP   | line held high for GAP_CYCLES cycles
module msg_ser_tx #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       inValid,
    output logic       inReady,
    input  logic [1:0] portNum,
    input  logic [3:0] byteNum,
    input  logic [7:0] dataIn,
    input  logic       dataValid,
    output logic       dataReady,
    output logic       serOut,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PORT,
        S_COUNT,
        S_DATA,
        S_GAP
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] port_q, port_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] fetch_q, fetch_d;
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic [3:0] byte_q, byte_d;
    logic [3:0] gap_q, gap_d;
    logic       ser_q, ser_d;
    logic       done_q, done_d;
    logic       underrun_q, underrun_d;

    logic       slot_load;
    logic       data_acc;
    logic [3:0] fetch_dec;

    assign inReady   = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign dataReady = !buf_full_q && (fetch_q != 4'd0) &&
                       ((state_q == S_START) || (state_q == S_PORT) ||
                        (state_q == S_COUNT) || (state_q == S_DATA));
    assign data_acc  = dataValid && dataReady;
    assign serOut    = ser_q;
    assign done      = done_q;
    assign underrun  = underrun_q;

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        cnt_d      = cnt_q;
        fetch_d    = fetch_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        gap_d      = gap_q;
        slot_load  = 1'b0;
        underrun_d = 1'b0;
        fetch_dec  = 4'd0;

        case (state_q)
            S_IDLE: begin
                if (inValid) begin
                    state_d    = S_START;
                    port_d     = portNum;
                    cnt_d      = byteNum;
                    fetch_d    = byteNum;
                    buf_full_d = 1'b0;
                    bit_d      = 3'd0;
                    byte_d     = 4'd0;
                    gap_d      = 4'd0;
                end
            end
            S_START: begin
                state_d = S_PORT;
                bit_d   = 3'd0;
            end
            S_PORT: begin
                if (bit_q == 3'd1) begin
                    state_d = S_COUNT;
                    bit_d   = 3'd0;
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
            S_COUNT: begin
                if (bit_q == 3'd3) begin
                    bit_d = 3'd0;
                    if (cnt_q != 4'd0) begin
                        state_d   = S_DATA;
                        byte_d    = 4'd0;
                        slot_load = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = 4'd0;
                    end
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
            S_DATA: begin
                shift_d = {shift_q[6:0], 1'b0};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    if (byte_q + 4'd1 == cnt_q) begin
                        state_d = S_GAP;
                        gap_d   = 4'd0;
                    end else begin
                        byte_d    = byte_q + 4'd1;
                        slot_load = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    gap_d   = 4'd0;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Slot load empties the buffer; a byte accepted on the same edge refills it for the next slot.
        if (slot_load) begin
            shift_d    = buf_full_q ? buf_q : 8'h00;
            buf_full_d = 1'b0;
            underrun_d = !buf_full_q;
        end
        if (data_acc) begin
            buf_d      = dataIn;
            buf_full_d = 1'b1;
        end

        if (state_q != S_IDLE) begin
            fetch_dec = {3'd0, data_acc} + {3'd0, underrun_d};
            fetch_d   = (fetch_q > fetch_dec) ? (fetch_q - fetch_dec) : 4'd0;
        end

        done_d = (state_d == S_GAP) && (state_q != S_GAP);

        case (state_d)
            S_START: ser_d = 1'b0;
            S_PORT:  ser_d = port_d[~bit_d[0]];
            S_COUNT: ser_d = cnt_d[2'd3 - bit_d[1:0]];
            S_DATA:  ser_d = shift_d[7];
            default: ser_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            port_q     <= 2'd0;
            cnt_q      <= 4'd0;
            fetch_q    <= 4'd0;
            buf_q      <= 8'h00;
            buf_full_q <= 1'b0;
            shift_q    <= 8'h00;
            bit_q      <= 3'd0;
            byte_q     <= 4'd0;
            gap_q      <= 4'd0;
            ser_q      <= 1'b1;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            cnt_q      <= cnt_d;
            fetch_q    <= fetch_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            gap_q      <= gap_d;
            ser_q      <= ser_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_msg_ser_tx.sv
// Directed bench for msg_ser_tx: frames are captured cycle by cycle and compared with hand-built bit strings.
module tb_msg_ser_tx;

    logic       Clk;
    logic       reset;
    logic       inValid;
    logic       inReady;
    logic [1:0] portNum;
    logic [3:0] byteNum;
    logic [7:0] dataIn;
    logic       dataValid;
    logic       dataReady;
    logic       serOut;
    logic       busy;
    logic       done;
    logic       underrun;

    int n_checks = 0;
    int n_pass   = 0;
    int acc_count = 0;
    logic [7:0] feed_q[$];

    logic [63:0] v_ser, v_done, v_ur, v_busy;

    msg_ser_tx #(.GAP_CYCLES(1)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .inValid   (inValid),
        .inReady   (inReady),
        .portNum   (portNum),
        .byteNum   (byteNum),
        .dataIn    (dataIn),
        .dataValid (dataValid),
        .dataReady (dataReady),
        .serOut    (serOut),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Request a frame, then scramble the request inputs to prove they were captured.
    task automatic send(input logic [1:0] p, input logic [3:0] n);
        portNum = p;
        byteNum = n;
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        portNum = ~p;
        byteNum = ~n;
    endtask

    // First sampled cycle ends up in the most significant of the n captured bits.
    task automatic collect(input int n);
        v_ser = '0; v_done = '0; v_ur = '0; v_busy = '0;
        for (int i = 0; i < n; i++) begin
            v_ser  = {v_ser[62:0], serOut};
            v_done = {v_done[62:0], done};
            v_ur   = {v_ur[62:0], underrun};
            v_busy = {v_busy[62:0], busy};
            tick();
        end
    endtask

    // Byte source: presents the head of feed_q and pops it once the handshake is seen.
    initial begin
        logic hs;
        dataValid = 1'b0;
        dataIn    = 8'h00;
        forever begin
            @(negedge Clk);
            hs = dataValid && dataReady;
            if (hs) acc_count++;
            @(posedge Clk);
            #1;
            if (hs && feed_q.size() > 0) void'(feed_q.pop_front());
            if (feed_q.size() > 0) begin
                dataValid = 1'b1;
                dataIn    = feed_q[0];
            end else begin
                dataValid = 1'b0;
                dataIn    = 8'h00;
            end
        end
    end

    initial begin
        logic dr_seen;

        reset   = 1'b1;
        inValid = 1'b1;
        portNum = 2'b11;
        byteNum = 4'd5;
        tick(); tick(); tick();
        check("rst_ser",      64'(serOut),    64'd1);
        check("rst_inready",  64'(inReady),   64'd1);
        check("rst_dataready",64'(dataReady), 64'd0);
        check("rst_busy",     64'(busy),      64'd0);
        check("rst_done",     64'(done),      64'd0);
        check("rst_underrun", 64'(underrun),  64'd0);
        reset   = 1'b0;
        inValid = 1'b0;
        tick();
        check("post_rst_busy", 64'(busy), 64'd0);

        // Empty frame, port 2
        send(2'b10, 4'd0);
        check("f0_inready_busy", 64'(inReady), 64'd0);
        collect(8);
        check("f0_ser",  v_ser[7:0],  64'(8'b0100_0001));
        check("f0_done", v_done[7:0], 64'(8'b0000_0001));
        check("f0_busy", v_busy[7:0], 64'(8'hFF));
        check("f0_idle_busy",    64'(busy),    64'd0);
        check("f0_idle_inready", 64'(inReady), 64'd1);

        // Two payload bytes offered from the header onward
        acc_count = 0;
        feed_q = '{8'hA5, 8'h3C};
        send(2'b01, 4'd2);
        collect(24);
        check("f2_ser",  v_ser[23:0], 64'({1'b0, 2'b01, 4'b0010, 8'hA5, 8'h3C, 1'b1}));
        check("f2_ur",   v_ur[23:0],  64'd0);
        check("f2_done", v_done[23:0], 64'(24'h000001));
        check("f2_acc",  64'(acc_count), 64'd2);

        // One byte, never supplied
        feed_q.delete();
        send(2'b11, 4'd1);
        collect(16);
        check("f1u_ser",  v_ser[15:0],  64'({1'b0, 2'b11, 4'b0001, 8'h00, 1'b1}));
        check("f1u_ur",   v_ur[15:0],   64'(16'h0100));
        check("f1u_done", v_done[15:0], 64'(16'h0001));

        // Back-to-back requests with inValid held high
        portNum = 2'b10;
        byteNum = 4'd0;
        inValid = 1'b1;
        tick();
        collect(11);
        inValid = 1'b0;
        check("b2b_ser",  v_ser[10:0],  64'(11'b0100000_1101));
        check("b2b_busy", v_busy[10:0], 64'(11'b11111111_011));
        for (int i = 0; i < 6; i++) tick();
        check("b2b_end_inready", 64'(inReady), 64'd1);

        // Reset during bit 3 of the second payload byte
        feed_q = '{8'hFF, 8'h00, 8'h77};
        send(2'b00, 4'd2);
        collect(18);
        check("rstm_pre_ser", 64'(serOut), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        feed_q.delete();
        check("rstm_ser",       64'(serOut),    64'd1);
        check("rstm_busy",      64'(busy),      64'd0);
        check("rstm_inready",   64'(inReady),   64'd1);
        check("rstm_dataready", 64'(dataReady), 64'd0);
        tick();
        feed_q = '{8'h81};
        send(2'b10, 4'd1);
        collect(16);
        check("rstm_next_ser", v_ser[15:0], 64'({1'b0, 2'b10, 4'b0001, 8'h81, 1'b1}));
        check("rstm_next_ur",  v_ur[15:0],  64'd0);

        // Data offered continuously: only byteNum bytes may be taken
        feed_q.delete();
        tick();
        acc_count = 0;
        feed_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send(2'b00, 4'd3);
        collect(32);
        check("f3_ser", v_ser[31:0], 64'({1'b0, 2'b00, 4'b0011, 8'h11, 8'h22, 8'h33, 1'b1}));
        check("f3_ur",  v_ur[31:0],  64'd0);
        dr_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dr_seen = dr_seen | dataReady;
            tick();
        end
        check("f3_dr_idle", 64'(dr_seen),   64'd0);
        check("f3_acc",     64'(acc_count), 64'd3);
        feed_q.delete();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
